// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX pipeline registers for the 5-stage MIPS core, applying hazard-unit hold/bubble/redirect.
// Optional saturating stall/flush event counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_stage_regs #(
  parameter int              WIDTH    = 32,
  parameter int              CTRL_W   = 10,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h00400000,
  parameter int              CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushE,
  input  logic              PCSrcD,
  input  logic [WIDTH-1:0]  PCBranchD,
  input  logic [31:0]       InstrF,
  output logic [WIDTH-1:0]  PCF,
  output logic [31:0]       InstrD,
  output logic [WIDTH-1:0]  PCPlus4D,
  output logic              ValidD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [WIDTH-1:0]  RD1D,
  input  logic [WIDTH-1:0]  RD2D,
  input  logic [WIDTH-1:0]  SignImmD,
  input  logic [4:0]        RsD,
  input  logic [4:0]        RtD,
  input  logic [4:0]        RdD,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [WIDTH-1:0]  RD1E,
  output logic [WIDTH-1:0]  RD2E,
  output logic [WIDTH-1:0]  SignImmE,
  output logic [4:0]        RsE,
  output logic [4:0]        RtE,
  output logic [4:0]        RdE,
  output logic              ValidE,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  logic [WIDTH-1:0]  pcF_r;
  logic [WIDTH-1:0]  pcPlus4F_s;
  logic [WIDTH-1:0]  pcNext_s;
  logic [31:0]       instrD_r;
  logic [31:0]       instrDNext_s;
  logic [WIDTH-1:0]  pcPlus4D_r;
  logic [WIDTH-1:0]  pcPlus4DNext_s;
  logic              validD_r;
  logic              validDNext_s;
  logic [CTRL_W-1:0] ctrlE_r;
  logic [WIDTH-1:0]  rd1E_r;
  logic [WIDTH-1:0]  rd2E_r;
  logic [WIDTH-1:0]  signImmE_r;
  logic [4:0]        rsE_r;
  logic [4:0]        rtE_r;
  logic [4:0]        rdE_r;
  logic              validE_r;

  // Sequential PC + 4 wraps naturally modulo 2^WIDTH.
  assign pcPlus4F_s = pcF_r + WIDTH'(3'd4);

  // Next fetch PC: hold on StallF, else redirect or fall through.
  always_comb begin
    pcNext_s = pcF_r;
    if (StallF) begin
      pcNext_s = pcF_r;
    end else if (PCSrcD) begin
      pcNext_s = PCBranchD;
    end else begin
      pcNext_s = pcPlus4F_s;
    end
  end

  // Next IF/ID contents: a stall beats a redirect, so a pending branch is taken once the stall releases.
  always_comb begin
    instrDNext_s   = instrD_r;
    pcPlus4DNext_s = pcPlus4D_r;
    validDNext_s   = validD_r;
    if (StallD) begin
      instrDNext_s   = instrD_r;
      pcPlus4DNext_s = pcPlus4D_r;
      validDNext_s   = validD_r;
    end else if (PCSrcD) begin
      instrDNext_s   = 32'h0000_0000;
      pcPlus4DNext_s = {WIDTH{1'b0}};
      validDNext_s   = 1'b0;
    end else begin
      instrDNext_s   = InstrF;
      pcPlus4DNext_s = pcPlus4F_s;
      validDNext_s   = 1'b1;
    end
  end

  // F and D stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcF_r      <= RESET_PC;
      instrD_r   <= 32'h0000_0000;
      pcPlus4D_r <= {WIDTH{1'b0}};
      validD_r   <= 1'b0;
    end else begin
      pcF_r      <= pcNext_s;
      instrD_r   <= instrDNext_s;
      pcPlus4D_r <= pcPlus4DNext_s;
      validD_r   <= validDNext_s;
    end
  end

  // ID/EX register: no hold path, a bubble is an all-zero bundle (no RegWrite, no MemWrite).
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      ctrlE_r    <= {CTRL_W{1'b0}};
      rd1E_r     <= {WIDTH{1'b0}};
      rd2E_r     <= {WIDTH{1'b0}};
      signImmE_r <= {WIDTH{1'b0}};
      rsE_r      <= 5'd0;
      rtE_r      <= 5'd0;
      rdE_r      <= 5'd0;
      validE_r   <= 1'b0;
    end else begin
      ctrlE_r    <= CtrlD;
      rd1E_r     <= RD1D;
      rd2E_r     <= RD2D;
      signImmE_r <= SignImmD;
      rsE_r      <= RsD;
      rtE_r      <= RtD;
      rdE_r      <= RdD;
      validE_r   <= validD_r;
    end
  end

  assign PCF      = pcF_r;
  assign InstrD   = instrD_r;
  assign PCPlus4D = pcPlus4D_r;
  assign ValidD   = validD_r;
  assign CtrlE    = ctrlE_r;
  assign RD1E     = rd1E_r;
  assign RD2E     = rd2E_r;
  assign SignImmE = signImmE_r;
  assign RsE      = rsE_r;
  assign RtE      = rtE_r;
  assign RdE      = rdE_r;
  assign ValidE   = validE_r;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stallCount_r;
  logic [CNT_W-1:0] flushCount_r;
  logic             bubble_s;

  // At most one flush event per cycle even when both bubble sources fire together.
  assign bubble_s = FlushE | (PCSrcD & ~StallD);

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCount_r <= {CNT_W{1'b0}};
      flushCount_r <= {CNT_W{1'b0}};
    end else begin
      if (StallD && (stallCount_r != CNT_MAX)) begin
        stallCount_r <= stallCount_r + CNT_W'(1'b1);
      end else begin
        stallCount_r <= stallCount_r;
      end
      if (bubble_s && (flushCount_r != CNT_MAX)) begin
        flushCount_r <= flushCount_r + CNT_W'(1'b1);
      end else begin
        flushCount_r <= flushCount_r;
      end
    end
  end

  assign StallCount = stallCount_r;
  assign FlushCount = flushCount_r;
`else
  assign StallCount = {CNT_W{1'b0}};
  assign FlushCount = {CNT_W{1'b0}};
`endif

endmodule
